hash_checker: RTL and testbench

- Stores a small table of 128-bit target hashes (NT/MD4 digests).
- Tests candidate digests against that table and reports whether any stored entry matches.
- Sits between the MD4 block and the cracking controller.
  - The controller loads targets one at a time during the loading phase.
  - Afterwards it submits every computed digest for a membership check.
- Runs on the divided core clock.

---
 rtl/hash_checker.sv | 145 ++++++++++++++
 tb/tb_hash_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_checker.sv
// hash_checker: table of 128-bit target digests with membership check.
// Define HASH_CHECKER_PARALLEL_EN for a single-cycle parallel scan.
module hash_checker #(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         newrdy,
  input  logic         checkrdy,
  input  logic [127:0] hash,
  output logic         resultrdy,
  output logic         matchfound
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STORE = 2'd1,
    SCAN  = 2'd2
  } state_t;

  state_t         state, state_d;
  logic           new_q, chk_q;
  logic           new_edge, chk_edge;
  logic [127:0]   hash_reg;
  logic [127:0]   tbl [DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  last;
  logic [IW-1:0]  idx, idx_d;
  logic           start, done, hit, wr_en;

  assign new_edge = newrdy & ~new_q;
  assign chk_edge = checkrdy & ~chk_q;
  assign last     = count - 1'b1;

`ifdef HASH_CHECKER_PARALLEL_EN
  logic [DEPTH-1:0] hit_vec;

  // One comparator per entry, masked by occupancy.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = (CW'(i) < count)
                && (tbl[i] == hash_reg);
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, scan stepping and completion strobes.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    start   = 1'b0;
    done    = 1'b0;
    hit     = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (new_edge) begin
          start   = 1'b1;
          state_d = STORE;
        end else if (chk_edge) begin
          start   = 1'b1;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      STORE: begin
        wr_en   = (count < DEPTH_C);
        done    = 1'b1;
        state_d = IDLE;
      end
      SCAN: begin
`ifdef HASH_CHECKER_PARALLEL_EN
        done    = 1'b1;
        hit     = |hit_vec;
        state_d = IDLE;
`else
        if (count == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tbl[idx] == hash_reg) begin
          done    = 1'b1;
          hit     = 1'b1;
          state_d = IDLE;
        end else if (CW'(idx) == last) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Request samples for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_q <= 1'b0;
      chk_q <= 1'b0;
    end else begin
      new_q <= newrdy;
      chk_q <= checkrdy;
    end
  end

  // Operand latch, occupancy, scan index and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_reg   <= '0;
      count      <= '0;
      idx        <= '0;
      resultrdy  <= 1'b0;
      matchfound <= 1'b0;
    end else begin
      idx <= idx_d;
      if (start) begin
        hash_reg  <= hash;
        resultrdy <= 1'b0;
      end
      if (wr_en) count <= count + 1'b1;
      if (done) begin
        resultrdy  <= 1'b1;
        matchfound <= hit;
      end
    end
  end

  // Digest storage; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) tbl[count[IW-1:0]] <= hash_reg;
  end

endmodule

// File: tb/tb_hash_checker.sv
// tb_hash_checker: directed test of hash_checker (sequential build).
// Each task drives one scenario and checks its own results inline.
module tb_hash_checker;

  localparam int D = 16;
  localparam logic [127:0] HA  = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
  localparam logic [127:0] HZ  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] HAB = 128'hDEADBEEF_00000000_CAFEF00D_00000001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         newrdy = 1'b0;
  logic         checkrdy = 1'b0;
  logic [127:0] hash = '0;
  logic         resultrdy;
  logic         matchfound;

  int n_chk = 0;
  int n_fail = 0;

  hash_checker #(.DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .newrdy     (newrdy),
    .checkrdy   (checkrdy),
    .hash       (hash),
    .resultrdy  (resultrdy),
    .matchfound (matchfound)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input int i);
    return {32'h5A5A0000 + 32'(i), 32'h0, 32'h1234, 32'(i)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    newrdy   = 1'b0;
    checkrdy = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One request: r0 = resultrdy after edge k, lat = cycles to rise.
  task automatic op(input bit is_new, input logic [127:0] h,
                    output logic r0, output int lat,
                    output logic mf);
    @(negedge clk);
    hash = h;
    if (is_new) newrdy = 1'b1;
    else checkrdy = 1'b1;
    @(posedge clk);
    #1;
    r0  = resultrdy;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (resultrdy === 1'b1) begin
        lat = n;
        break;
      end
    end
    mf = matchfound;
    @(negedge clk);
    newrdy   = 1'b0;
    checkrdy = 1'b0;
  endtask

  task automatic test_reset();
    logic r0, mf;
    int lat;
    do_reset();
    #1;
    n_chk++;
    if (resultrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_resultrdy got %b exp 0", resultrdy);
    end
    n_chk++;
    if (matchfound !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_matchfound got %b exp 0", matchfound);
    end
    op(1'b0, HZ, r0, lat, mf);
    n_chk++;
    if (r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_drop got %b exp 0", r0);
    end
    n_chk++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL empty_lat got %0d exp 1", lat);
    end
    n_chk++;
    if (mf !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_match got %b exp 0", mf);
    end
  endtask

  task automatic test_store_check();
    logic r0, mf;
    int lat;
    op(1'b1, HA, r0, lat, mf);
    n_chk++;
    if (r0 !== 1'b0 || lat !== 1 || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL store_a got r0=%b lat=%0d mf=%b exp 0/1/0",
               r0, lat, mf);
    end
    op(1'b0, HA, r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL check_a got lat=%0d mf=%b exp 1/1", lat, mf);
    end
    op(1'b0, HA ^ 128'h1, r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL check_a1 got lat=%0d mf=%b exp 1/0", lat, mf);
    end
  endtask

  task automatic test_five();
    logic r0, mf;
    int lat;
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, mk(i), r0, lat, mf);
    op(1'b0, mk(3), r0, lat, mf);
    n_chk++;
    if (r0 !== 1'b0 || lat !== 4 || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL five_hit got r0=%b lat=%0d mf=%b exp 0/4/1",
               r0, lat, mf);
    end
    op(1'b0, HAB, r0, lat, mf);
    n_chk++;
    if (lat !== 5 || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL five_miss got lat=%0d mf=%b exp 5/0", lat, mf);
    end
    op(1'b0, mk(0), r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL five_first got lat=%0d mf=%b exp 1/1", lat, mf);
    end
  endtask

  task automatic test_full();
    logic r0, mf;
    int lat;
    do_reset();
    for (int i = 0; i < D; i++) op(1'b1, mk(i + 100), r0, lat, mf);
    op(1'b0, mk(D + 99), r0, lat, mf);
    n_chk++;
    if (lat !== D || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL full_last got lat=%0d mf=%b exp %0d/1",
               lat, mf, D);
    end
    op(1'b1, HAB, r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_store got lat=%0d mf=%b exp 1/0", lat, mf);
    end
    op(1'b0, HAB, r0, lat, mf);
    n_chk++;
    if (lat !== D || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_dropped got lat=%0d mf=%b exp %0d/0",
               lat, mf, D);
    end
    op(1'b0, mk(100), r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL full_entry0 got lat=%0d mf=%b exp 1/1", lat, mf);
    end
  endtask

  task automatic test_simul_hold();
    logic r0, mf, prev;
    int lat, rises, falls;
    do_reset();
    @(negedge clk);
    hash     = HA;
    newrdy   = 1'b1;
    checkrdy = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (resultrdy === 1'b1 && prev === 1'b0) rises++;
      prev = resultrdy;
    end
    n_chk++;
    if (rises !== 1) begin
      n_fail++;
      $display("FAIL simul_rises got %0d exp 1", rises);
    end
    @(negedge clk);
    newrdy   = 1'b0;
    checkrdy = 1'b0;
    op(1'b0, HA, r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_stored got lat=%0d mf=%b exp 1/1", lat, mf);
    end
    @(negedge clk);
    hash     = HAB;
    checkrdy = 1'b1;
    rises = 0;
    falls = 0;
    prev  = resultrdy;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (resultrdy === 1'b1 && prev === 1'b0) rises++;
      if (resultrdy === 1'b0 && prev === 1'b1) falls++;
      prev = resultrdy;
    end
    n_chk++;
    if (rises !== 1 || falls !== 1) begin
      n_fail++;
      $display("FAIL hold_once got rises=%0d falls=%0d exp 1/1",
               rises, falls);
    end
    n_chk++;
    if (matchfound !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_match got %b exp 0", matchfound);
    end
    @(negedge clk);
    checkrdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic r0, mf;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) op(1'b1, mk(i + 50), r0, lat, mf);
    op(1'b0, mk(50), r0, lat, mf);
    @(negedge clk);
    hash     = HAB;
    checkrdy = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (resultrdy !== 1'b0 || matchfound !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy got rr=%b mf=%b exp 0/1",
               resultrdy, matchfound);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (resultrdy !== 1'b0 || matchfound !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got rr=%b mf=%b exp 0/0",
               resultrdy, matchfound);
    end
    @(negedge clk);
    checkrdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, mk(50), r0, lat, mf);
    n_chk++;
    if (lat !== 1 || mf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after got lat=%0d mf=%b exp 1/0", lat, mf);
    end
  endtask

  initial begin
    test_reset();
    test_store_check();
    test_five();
    test_full();
    test_simul_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
